// File: rtl/fpga_msg_framer.sv
// Frames an application word stream for the FPGA-to-PC xillybus FIFO:
// header word, FRAME_LEN buffered payload words, then a zero-sum checksum word.
module fpga_msg_framer #(
  parameter int XB_SIZE   = 32,
  parameter int FRAME_LEN = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fpga_msg_valid,
  input  logic [XB_SIZE-1:0] fpga_msg,
  output logic               fpga_msg_full,
  input  logic               xb_full,
  output logic               xb_wren,
  output logic [XB_SIZE-1:0] xb_data,
  output logic [7:0]         frame_seq,
  output logic               error,
  output logic [1:0]         dbg_state_o
);

  localparam int DEPTH = 2 * FRAME_LEN;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int IDX_W = $clog2(FRAME_LEN);

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, CKSUM} state_t;

  // Input handshake: a word moves when fpga_msg_valid=1 and fpga_msg_full=0.
  // Output handshake: a word moves on every rising edge where xb_wren=1.
  state_t             state_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [31:0]        acc_q;
  logic [7:0]         seq_q;
  logic               error_q;
  logic [XB_SIZE-1:0] mem_q [DEPTH];

  logic               push, pop, xfer;
  logic [XB_SIZE-1:0] rd_word;
  logic [31:0]        rd_lo, hdr_word, cksum_word;

  assign fpga_msg_full = (count_q == CNT_W'(DEPTH));
  assign xb_wren       = (state_q != IDLE) && !xb_full;
  assign xfer          = xb_wren;
  assign push          = fpga_msg_valid && !fpga_msg_full;
  assign pop           = (state_q == PAYLOAD) && xfer;
  assign count_d       = count_q + CNT_W'(push) - CNT_W'(pop);

  assign rd_word    = mem_q[rd_ptr_q];
  assign rd_lo      = rd_word[31:0];
  assign hdr_word   = {8'hA5, seq_q, 16'(FRAME_LEN)};
  // Negated running sum makes the 32-bit sum of the whole frame zero.
  assign cksum_word = ~acc_q + 32'd1;

  assign frame_seq   = seq_q;
  assign error       = error_q;
  assign dbg_state_o = state_q;

  always_comb begin
    xb_data = '0;
    case (state_q)
      HDR:     xb_data = XB_SIZE'(hdr_word);
      PAYLOAD: xb_data = rd_word;
      CKSUM:   xb_data = XB_SIZE'(cksum_word);
      default: xb_data = '0;
    endcase
  end

  // Storage is not reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= fpga_msg;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      seq_q    <= '0;
      error_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (fpga_msg_valid && fpga_msg_full) error_q <= 1'b1;

      case (state_q)
        IDLE: begin
          if (count_q >= CNT_W'(FRAME_LEN)) begin
            state_q <= HDR;
            acc_q   <= hdr_word;
          end
        end
        HDR: begin
          if (xfer) begin
            state_q <= PAYLOAD;
            idx_q   <= '0;
          end
        end
        PAYLOAD: begin
          if (xfer) begin
            acc_q <= acc_q + rd_lo;
            idx_q <= idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(FRAME_LEN - 1)) state_q <= CKSUM;
          end
        end
        CKSUM: begin
          if (xfer) begin
            seq_q   <= seq_q + 8'd1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_msg_framer.sv
// Bench for fpga_msg_framer: directed cases plus a long randomized stream,
// checked by a queue-based frame model and an independent monitor.
module tb_fpga_msg_framer;

  localparam int W     = 32;
  localparam int N     = 8;
  localparam int DEPTH = 2 * N;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         fpga_msg_valid = 1'b0;
  logic [W-1:0] fpga_msg = '0;
  logic         fpga_msg_full;
  logic         xb_full = 1'b0;
  logic         xb_wren;
  logic [W-1:0] xb_data;
  logic [7:0]   frame_seq;
  logic         error;
  logic [1:0]   dbg_state;

  fpga_msg_framer #(.XB_SIZE(W), .FRAME_LEN(N)) dut (
    .clk            (clk),
    .reset          (reset),
    .fpga_msg_valid (fpga_msg_valid),
    .fpga_msg       (fpga_msg),
    .fpga_msg_full  (fpga_msg_full),
    .xb_full        (xb_full),
    .xb_wren        (xb_wren),
    .xb_data        (xb_data),
    .frame_seq      (frame_seq),
    .error          (error),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int passes = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] pend_q[$];
  int           occ;
  int           out_pos;
  int           frames_done;
  int           cyc = 0;
  int           last_acc_cyc, hdr_cyc, cks_cyc;
  logic [7:0]   mseq, out_seq;
  logic         exp_err;
  logic [31:0]  obs_sum;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic timeout_fail(input string name, input int budget);
    checks++;
    $display("FAIL %s: condition not reached within %0d cycles, %0d words outstanding",
             name, budget, exp_q.size());
  endtask

  // ---------------- monitor / reference model ----------------
  // Sampled at negedge: inputs and outputs describe the next rising edge.
  always @(negedge clk) begin : monitor
    logic [31:0]  s;
    logic [W-1:0] w, e;
    int           pop_n;
    cyc++;
    if (!reset) begin
      exp_q.delete();
      pend_q.delete();
      occ = 0; out_pos = 0; frames_done = 0;
      mseq = 8'd0; out_seq = 8'd0; exp_err = 1'b0; obs_sum = 32'd0;
    end else begin
      pop_n = 0;
      check("fpga_msg_full", fpga_msg_full, 32'(occ == DEPTH));
      check("error", error, 32'(exp_err));
      check("frame_seq", frame_seq, out_seq);
      if (xb_full) check("wren_under_xb_full", xb_wren, 0);
      if (xb_wren) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_wren: xb_data=%h with no word expected (cycle %0d)", xb_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("xb_data", xb_data, e);
        end
        obs_sum = obs_sum + xb_data[31:0];
        if (out_pos == 0) hdr_cyc = cyc;
        if (out_pos == N + 1) begin
          check("frame_sum_zero", obs_sum, 0);
          obs_sum = 32'd0;
          out_seq = out_seq + 8'd1;
          frames_done++;
          cks_cyc = cyc;
          out_pos = 0;
        end else begin
          if (out_pos >= 1) pop_n = 1;
          out_pos++;
        end
      end
      if (fpga_msg_valid) begin
        if (occ < DEPTH) begin
          pend_q.push_back(fpga_msg);
          occ++;
          last_acc_cyc = cyc;
          if (pend_q.size() == N) begin
            s = {8'hA5, mseq, 16'(N)};
            exp_q.push_back(s);
            for (int k = 0; k < N; k++) begin
              w = pend_q.pop_front();
              s = s + w;
              exp_q.push_back(w);
            end
            exp_q.push_back(32'd0 - s);
            mseq = mseq + 8'd1;
          end
        end else begin
          exp_err = 1'b1;
        end
      end
      occ = occ - pop_n;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    xb_full = 1'b0;
    for (int i = 0; i < n; i++) begin
      fpga_msg_valid = 1'b1;
      fpga_msg = $urandom;
      tick();
    end
    fpga_msg_valid = 1'b0;
    reset = 1'b1;
  endtask

  task automatic write_seq(input logic [W-1:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fpga_msg_valid = 1'b1;
      fpga_msg = first + W'(i);
      tick();
    end
    fpga_msg_valid = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && out_pos == 0) && n < budget) begin
      tick();
      n++;
    end
    if (!(exp_q.size() == 0 && out_pos == 0)) timeout_fail("drain", budget);
    tick();
  endtask

  task automatic wait_pos(input int pos, input int budget);
    int n = 0;
    while (out_pos != pos && n < budget) begin
      tick();
      n++;
    end
    if (out_pos != pos) timeout_fail("wait_frame_pos", budget);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // reset with valid held high: nothing may be buffered
    do_reset(4);
    @(negedge clk);
    check("rst_wren", xb_wren, 0);
    check("rst_full", fpga_msg_full, 0);
    check("rst_error", error, 0);
    check("rst_seq", frame_seq, 0);
    check("rst_data", xb_data, 0);
    repeat (12) tick();
    check("rst_nothing_buffered", xb_wren, 0);

    // single frame 1..8: latency and length
    write_seq(32'd1, N);
    drain(100);
    check("hdr_latency", 32'(hdr_cyc - last_acc_cyc), 2);
    check("frame_wren_span", 32'(cks_cyc - hdr_cyc), N + 1);
    check("seq_after_single", frame_seq, 1);

    // backpressure on payload word 4
    do_reset(1);
    write_seq(32'd1, N);
    wait_pos(4, 50);
    xb_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_wren", xb_wren, 0);
      check("stall_data", xb_data, 4);
      tick();
    end
    xb_full = 1'b0;
    drain(100);

    // fill with downstream blocked: 17th word dropped
    do_reset(1);
    xb_full = 1'b1;
    write_seq(32'd1, 17);
    @(negedge clk);
    check("fill_full", fpga_msg_full, 1);
    check("fill_error", error, 1);
    tick();
    xb_full = 1'b0;
    drain(200);
    check("fill_error_sticky", error, 1);
    check("fill_seq", frame_seq, 2);

    // 24 words back-to-back
    do_reset(1);
    write_seq(32'h1000_0000, 3 * N);
    drain(200);
    check("stream_seq", frame_seq, 3);

    // reset during payload word 3, then a clean frame with seq 0
    write_seq(32'hABCD_0000, N);
    wait_pos(3, 50);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    check("midrst_wren", xb_wren, 0);
    check("midrst_seq", frame_seq, 0);
    check("midrst_full", fpga_msg_full, 0);
    check("midrst_state_idle", dbg_state, 0);
    tick();
    write_seq(32'h5555_0000, N);
    drain(100);
    check("midrst_seq_after", frame_seq, 1);

    // long randomized stream past the 8-bit sequence wrap
    do_reset(1);
    begin
      int n = 0;
      while (frames_done < 257 && n < 30000) begin
        xb_full = ($urandom_range(0, 9) < 2);
        fpga_msg_valid = !fpga_msg_full && ($urandom_range(0, 9) < 7);
        fpga_msg = $urandom;
        tick();
        n++;
      end
      fpga_msg_valid = 1'b0;
      xb_full = 1'b0;
      if (frames_done < 257) timeout_fail("random_stream_frames", 30000);
      drain(300);
      check("wrap_seq", frame_seq, 8'(frames_done));
      check("random_no_error", error, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fpga_msg_framer.md
Name: fpga_msg_framer

Overview:
- Sits directly downstream of the application block: consumes its fpga_msg stream (valid/full handshake) and writes framed words into the FPGA-to-PC xillybus FIFO (wren/full).
- Buffers application words and groups them into fixed-length frames.
- Each frame is one header word, then FRAME_LEN payload words, then one checksum word, so host software can resynchronise and detect corruption.

Parameters:
- XB_SIZE, 32, xillybus word width; must be ≥32 (header/checksum use the low 32 bits, upper bits zero).
- FRAME_LEN, 8, payload words per frame; power of 2, 2..256.
- Derived, not overridable:
  - DEPTH = 2*FRAME_LEN, buffer depth.
  - CNT_W = log2(DEPTH)+1.

Ports:
- clk  in  1  single clock for whole block.
- reset  in  1  synchronous, active-low (asserted when 0, sampled on rising clk).
- fpga_msg_valid  in  1  application presents a word.
- fpga_msg  in  XB_SIZE  application word.
- fpga_msg_full  out  1  buffer cannot accept; application must hold off.
- xb_full  in  1  downstream FIFO full.
- xb_wren  out  1  write strobe to downstream FIFO.
- xb_data  out  XB_SIZE  word written when xb_wren=1.
- frame_seq  out  8  sequence number of the next frame to be emitted.
- error  out  1  sticky overflow flag.

Behaviour:
- Reset (reset=0 at rising edge):
  - Buffer count 0, read/write pointers 0, state IDLE.
  - frame_seq=0, checksum accumulator 0, error=0.
  - Outputs during and after reset until first frame: xb_wren=0, fpga_msg_full=0, xb_data=0.
  - Reset mid-frame discards the partial frame and all buffered words; no resume.
- Input side:
  - Circular buffer of DEPTH words.
  - fpga_msg_full = (count == DEPTH), combinational from registered count.
  - Word accepted at rising edge when fpga_msg_valid=1 and fpga_msg_full=0; it is written at wr_ptr, and wr_ptr wraps modulo DEPTH.
  - fpga_msg_valid=1 while fpga_msg_full=1: word dropped, error set to 1, error stays 1 until reset.
  - Simultaneous accept and payload pop in the same cycle: count unchanged, both pointers advance.
- Output side:
  - xb_wren = (state != IDLE) && !xb_full, combinational.
  - A word is transferred at each rising edge with xb_wren=1.
  - xb_data driven from registered state, stable while stalled.
- State machine:
  - IDLE: if count ≥ FRAME_LEN go to HDR; load checksum accumulator with header value.
  - HDR:
    - xb_data = {8'hA5, frame_seq, 16'(FRAME_LEN)}.
    - On transfer go to PAYLOAD, word index 0.
  - PAYLOAD:
    - xb_data = buffer[rd_ptr].
    - On transfer: pop (rd_ptr++, count--), accumulator += word (mod 2^32), index++.
    - After index FRAME_LEN-1 is transferred go to CKSUM.
  - CKSUM:
    - xb_data = two's complement of accumulator, so the 32-bit sum of all FRAME_LEN+2 frame words is 0.
    - On transfer: frame_seq++ (wraps 255→0), go to IDLE.
  - Minimum one IDLE cycle between frames.
  - xb_full=1 in any non-IDLE state stalls with no state/pointer change; zero data loss.
- Latency: header xb_wren rises 2 cycles after the edge accepting the FRAME_LEN-th buffered word (given xb_full=0). An unstalled frame is FRAME_LEN+2 consecutive wren cycles.
- Throughput: the application can keep writing up to FRAME_LEN further words while a frame drains.

Test Plan:
- Reset: reset=0 for 4 cycles with fpga_msg_valid=1 → xb_wren=0, fpga_msg_full=0, error=0, frame_seq=0, nothing buffered after release.
- Single frame (FRAME_LEN=8), write words 1..8, xb_full=0 → xb_wren high for 10 consecutive cycles starting 2 cycles after 8th accept; data 0xA5000008, 1..8, 0x5AFFFFD4; frame_seq becomes 1.
- Backpressure: same frame, xb_full=1 for 5 cycles while payload word 4 is presented → xb_wren=0 and xb_data=4 held for 5 cycles; then 4..8 and 0x5AFFFFD4 emitted, nothing lost or duplicated.
- Fill: xb_full=1, write 17 words back-to-back → fpga_msg_full=1 after 16th accept; 17th dropped, error=1 and remains 1. Release xb_full → two frames, seq 0 then 1, payload words 1..16.
- Streaming: 24 words continuous, xb_full=0 → three frames, seq 0,1,2, each with frame sum 0 mod 2^32. Extend to 257 frames → frame_seq wraps 255→0 in header byte.
- Reset mid-frame: reset=0 for one cycle during PAYLOAD word 3 → next cycle xb_wren=0, count 0, frame_seq 0. Next 8 writes produce a clean header with seq 0.
